rom_bus_sequencer: RTL and testbench
====================================

Name: rom_bus_sequencer

Overview:
- Program-fetch initiator for the bus sequencer's command ROM.
- On a start pulse it issues ROM reads from address 0 and treats each returned DATA_WIDTH-bit word as a command.
- Executes each command as a valid/ready bus write, a programmed delay, a jump or an end marker.
- Sits between the command ROM (1-cycle registered read, `rden`-gated) and the downstream peripheral bus.

Parameters:
- ROM_DEPTH, 16, number of ROM words; program counter (PC) width = $clog2(ROM_DEPTH).
- DATA_WIDTH, 13, command word width; fixed layout {op[12:10], payload[9:0]}; must be 13.
- BUS_ADDR_W, 2, bus address width, taken from payload[9:8].
- BUS_DATA_W, 8, bus data width, taken from payload[7:0].

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- busy_o  out  1  high from the cycle after an accepted start until the cycle done_o or err_o pulses.
- done_o  out  1  one-cycle pulse on a normal END.
- err_o  out  1  one-cycle pulse on a fault.
- rom_addr_o  out  32  ROM word address; zero-extended PC.
- rom_rden_o  out  1  ROM read enable.
- rom_data_i  in  DATA_WIDTH  ROM data; valid the cycle after rom_rden_o=1.
- bus_valid_o  out  1  bus write request.
- bus_ready_i  in  1  bus accept; a transfer completes on valid&ready.
- bus_addr_o  out  BUS_ADDR_W  write address.
- bus_data_o  out  BUS_DATA_W  write data.

Behaviour:
- Reset: state IDLE, PC=0, delay counter=0. busy_o, done_o, err_o, rom_rden_o, bus_valid_o = 0. rom_addr_o, bus_addr_o, bus_data_o = 0.
- Reset asserted mid-operation aborts immediately: no done_o or err_o, bus_valid_o drops asynchronously.
- Opcodes:
  - NOP = 0
  - WR = 1
  - DLY = 2
  - JMP = 3
  - END = 7
  - 4, 5, 6 are illegal.
- States:
  - IDLE: start_i -> FETCH with PC=0, busy_o=1.
  - FETCH: rom_rden_o=1 for exactly one cycle with rom_addr_o=PC -> WAIT_DATA.
  - WAIT_DATA: capture rom_data_i into an instruction register -> EXEC.
  - EXEC, by opcode:
    - NOP: PC+1 -> FETCH.
    - WR: load bus_addr_o/bus_data_o, bus_valid_o=1 -> BUS.
    - DLY: counter = payload -> DELAY; payload 0 behaves as NOP.
    - JMP: PC = payload[PCW-1:0] -> FETCH; payload >= ROM_DEPTH -> FAULT.
    - END -> FINISH.
    - Illegal opcode -> FAULT.
  - BUS: bus_valid_o and the bus_addr_o/bus_data_o values held stable until bus_ready_i=1. In the accept cycle: PC+1 -> FETCH, bus_valid_o=0 next cycle. bus_ready_i asserted before valid has no effect. No timeout.
  - DELAY: counter decrements each cycle; leaving on counter==1 gives exactly `payload` cycles in DELAY. Then PC+1 -> FETCH.
  - FINISH: done_o=1, busy_o=0 same cycle -> IDLE.
  - FAULT: err_o=1, busy_o=0 same cycle -> IDLE.
- PC increment from ROM_DEPTH-1 (no wrap) -> FAULT.
- Cost per non-bus command: 3 cycles (FETCH, WAIT_DATA, EXEC), plus handshake or delay cycles.
- start_i in the same cycle as FINISH/FAULT is ignored; start_i in IDLE the next cycle is accepted.
- rom_rden_o is never asserted outside FETCH. rom_addr_o holds the last PC when idle.

Decomposition:
- Package rom_bus_seq_pkg holds:
  - opcode enum op_e (3-bit) and state enum state_e;
  - field-position constants OP_MSB=12, OP_LSB=10, PAYLOAD_W=10;
  - a packed struct cmd_t {op_e op; logic [9:0] payload}.
- One sub-module, seq_delay_counter: 10-bit load/decrement with a done flag, used by the DELAY state.
- FSM, PC and bus output registers stay in the top module.

Test Plan:
- Program {WR a=2 d=0xA5, END}, bus_ready_i tied 1 -> one transfer addr=2 data=0xA5. done_o fires 7 cycles after start_i; busy_o is 1 for those 7 cycles.
- Same program, bus_ready_i held 0 for 5 cycles -> bus_valid_o stays high with stable addr/data for 6 cycles, single transfer, then done_o.
- Program {DLY 4, WR a=1 d=0x3C, END} -> exactly 4 DELAY cycles; first bus_valid_o occurs 10 cycles after start_i.
- Program {JMP 3, WR a=0 d=0xFF, NOP, END} -> no bus transfer, done_o; ROM addresses read in order 0, 3.
- Program {opcode 5} at address 0 -> err_o pulse, no done_o, no bus_valid_o. Also: JMP 20 with ROM_DEPTH=16 -> err_o.
- rst_i asserted while in BUS state -> bus_valid_o and busy_o drop immediately, no done_o/err_o. A later start_i re-fetches from address 0.

Source files
------------

// File: rtl/rom_bus_seq_pkg.sv
`timescale 1ns/1ps
// rom_bus_seq_pkg
// Shared types and constants for the ROM-driven bus sequencer.
//   op_e      : 3-bit command opcode (values 4..6 are illegal)
//   state_e   : sequencer FSM states
//   cmd_t     : decoded command word {op, payload}
//   to_cmd()  : splits a raw 13-bit ROM word into a cmd_t
package rom_bus_seq_pkg;

    localparam int OP_MSB    = 12;
    localparam int OP_LSB    = 10;
    localparam int PAYLOAD_W = 10;
    localparam int CMD_W     = OP_MSB + 1;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_WR  = 3'd1,
        OP_DLY = 3'd2,
        OP_JMP = 3'd3,
        OP_END = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_EXEC,
        S_BUS,
        S_DELAY,
        S_FINISH,
        S_FAULT
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_t;

    function automatic cmd_t to_cmd(input logic [CMD_W-1:0] word);
        cmd_t c;
        c.op      = op_e'(word[OP_MSB:OP_LSB]);
        c.payload = word[PAYLOAD_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/rom_bus_sequencer_delay_counter.sv
`timescale 1ns/1ps
// seq_delay_counter
// Load/decrement counter backing the DELAY state.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load 'value' into the counter
//   dec      : decrement by one (saturates at zero)
//   value    : load value (DLY payload)
//   done     : high while the count is 1, i.e. in the last delay cycle
module seq_delay_counter
    import rom_bus_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 dec,
    input  logic [PAYLOAD_W-1:0] value,
    output logic                 done
);

    logic [PAYLOAD_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Exiting while the count reads 1 makes the DELAY state last exactly
    // 'value' cycles, since the load happens on the way into DELAY.
    assign done = (count_reg == PAYLOAD_W'(1));

endmodule

// File: rtl/rom_bus_sequencer.sv
`timescale 1ns/1ps
// rom_bus_sequencer
// Fetches commands from a 1-cycle registered command ROM starting at
// address 0 and executes them: bus write (valid/ready), delay, jump, NOP,
// end. Illegal opcodes, out-of-range jumps and running off the end of the
// ROM raise err_o.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : start pulse, ignored while busy
//   busy_o/done_o/err_o : status; done_o/err_o are single-cycle pulses
//   rom_addr_o/rom_rden_o/rom_data_i : command ROM read port
//   bus_valid_o/bus_ready_i/bus_addr_o/bus_data_o : peripheral write bus
module rom_bus_sequencer
    import rom_bus_seq_pkg::*;
#(
    parameter int ROM_DEPTH  = 16,
    parameter int DATA_WIDTH = 13,
    parameter int BUS_ADDR_W = 2,
    parameter int BUS_DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rom_addr_o,
    output logic                  rom_rden_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic [BUS_ADDR_W-1:0] bus_addr_o,
    output logic [BUS_DATA_W-1:0] bus_data_o
);

    localparam int PCW = $clog2(ROM_DEPTH);
    localparam logic [PCW-1:0] PC_LAST = PCW'(ROM_DEPTH - 1);

    state_e                state_reg;
    logic [PCW-1:0]        pc_reg;
    cmd_t                  instr_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic                  rden_reg;
    logic                  valid_reg;
    logic [BUS_ADDR_W-1:0] baddr_reg;
    logic [BUS_DATA_W-1:0] bdata_reg;

    logic advance;
    logic jmp_bad;
    logic dly_load;
    logic dly_dec;
    logic dly_done;

    seq_delay_counter u_delay (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (dly_load),
        .dec   (dly_dec),
        .value (instr_reg.payload),
        .done  (dly_done)
    );

    assign dly_load = (state_reg == S_EXEC) && (instr_reg.op == OP_DLY);
    assign dly_dec  = (state_reg == S_DELAY);
    assign jmp_bad  = ({{(32-PAYLOAD_W){1'b0}}, instr_reg.payload} >= 32'(ROM_DEPTH));

    // Every "move to the next command" exit funnels through one place so the
    // end-of-ROM check is applied uniformly (NOP, DLY 0, bus accept, delay end).
    always_comb begin
        advance = 1'b0;
        case (state_reg)
            S_EXEC:  advance = (instr_reg.op == OP_NOP) ||
                               ((instr_reg.op == OP_DLY) && (instr_reg.payload == '0));
            S_BUS:   advance = bus_ready_i;
            S_DELAY: advance = dly_done;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rden_reg  <= 1'b0;
            valid_reg <= 1'b0;
            baddr_reg <= '0;
            bdata_reg <= '0;
        end else begin
            rden_reg <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (advance) begin
                valid_reg <= 1'b0;
                if (pc_reg == PC_LAST) begin
                    state_reg <= S_FAULT;
                    err_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                end else begin
                    pc_reg    <= pc_reg + 1'b1;
                    rden_reg  <= 1'b1;
                    state_reg <= S_FETCH;
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start_i) begin
                            pc_reg    <= '0;
                            rden_reg  <= 1'b1;
                            busy_reg  <= 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end
                    S_FETCH:     state_reg <= S_WAIT_DATA;
                    S_WAIT_DATA: begin
                        instr_reg <= to_cmd(rom_data_i);
                        state_reg <= S_EXEC;
                    end
                    S_EXEC: begin
                        case (instr_reg.op)
                            OP_NOP: state_reg <= S_EXEC;
                            OP_WR: begin
                                valid_reg <= 1'b1;
                                baddr_reg <= instr_reg.payload[PAYLOAD_W-1 -: BUS_ADDR_W];
                                bdata_reg <= instr_reg.payload[BUS_DATA_W-1:0];
                                state_reg <= S_BUS;
                            end
                            OP_DLY: state_reg <= S_DELAY;
                            OP_JMP: begin
                                if (jmp_bad) begin
                                    state_reg <= S_FAULT;
                                    err_reg   <= 1'b1;
                                    busy_reg  <= 1'b0;
                                end else begin
                                    pc_reg    <= instr_reg.payload[PCW-1:0];
                                    rden_reg  <= 1'b1;
                                    state_reg <= S_FETCH;
                                end
                            end
                            OP_END: begin
                                state_reg <= S_FINISH;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                            end
                            default: begin
                                state_reg <= S_FAULT;
                                err_reg   <= 1'b1;
                                busy_reg  <= 1'b0;
                            end
                        endcase
                    end
                    S_BUS, S_DELAY:     state_reg <= state_reg;
                    S_FINISH, S_FAULT:  state_reg <= S_IDLE;
                    default:            state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign rom_rden_o  = rden_reg;
    assign rom_addr_o  = {{(32-PCW){1'b0}}, pc_reg};
    assign bus_valid_o = valid_reg;
    assign bus_addr_o  = baddr_reg;
    assign bus_data_o  = bdata_reg;

endmodule

// File: tb/tb_rom_bus_sequencer.sv
`timescale 1ns/1ps
module tb_rom_bus_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rom_addr_o;
    logic        rom_rden_o;
    logic [12:0] rom_data_i;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic [1:0]  bus_addr_o;
    logic [7:0]  bus_data_o;

    rom_bus_sequencer #(
        .ROM_DEPTH(16), .DATA_WIDTH(13), .BUS_ADDR_W(2), .BUS_DATA_W(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rom_addr_o(rom_addr_o), .rom_rden_o(rom_rden_o), .rom_data_i(rom_data_i),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Command ROM with a 1-cycle registered, rden-gated read.
    logic [12:0] rom [16];
    initial rom_data_i = '0;
    always @(posedge clk_i) if (rom_rden_o) rom_data_i <= rom[rom_addr_o[3:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] mk(input int op, input int payload);
        logic [2:0] o;
        logic [9:0] p;
        o = op[2:0];
        p = payload[9:0];
        return {o, p};
    endfunction

    function automatic logic [12:0] wr(input int a, input int d);
        return mk(1, a * 256 + d);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = mk(7, 0);
    endtask

    // Expected per-cycle behaviour, cycle 0 = the cycle start_i is high.
    int e_busy[64], e_done[64], e_err[64], e_valid[64], e_rden[64];
    int e_raddr[64], e_baddr[64], e_bdata[64];
    int m_end, m_last_pc;

    // Command-level interpreter: each command costs fetch+wait+exec, then
    // handshake/delay cycles; END/fault occupy the following cycle.
    task automatic model(input int ready_from);
        int t, pc, op, pl, nxt;
        bit fin, acc;
        for (int i = 0; i < 64; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_valid[i] = 0;
            e_rden[i] = 0; e_raddr[i] = 0; e_baddr[i] = 0; e_bdata[i] = 0;
        end
        t = 1; pc = 0; fin = 0; m_last_pc = 0;
        while (!fin) begin
            if (t > 50) begin
                n_checks++; n_fail++;
                $display("FAIL model bound: got %0d cycles expected <= 50", t);
                fin = 1;
            end else begin
                e_busy[t] = 1; e_rden[t] = 1; e_raddr[t] = pc; m_last_pc = pc;
                e_busy[t+1] = 1; e_busy[t+2] = 1;
                t += 3;
                op = int'(rom[pc][12:10]);
                pl = int'(rom[pc][9:0]);
                nxt = pc + 1;
                case (op)
                    0: ;
                    1: begin
                        acc = 0;
                        while (!acc && t < 55) begin
                            e_busy[t] = 1; e_valid[t] = 1;
                            e_baddr[t] = pl / 256; e_bdata[t] = pl % 256;
                            acc = (t >= ready_from);
                            t++;
                        end
                    end
                    2: for (int k = 0; k < pl && t < 55; k++) begin
                        e_busy[t] = 1; t++;
                    end
                    3: nxt = pl;
                    7: begin e_done[t] = 1; fin = 1; end
                    default: begin e_err[t] = 1; fin = 1; end
                endcase
                if (!fin && nxt >= 16) begin e_err[t] = 1; fin = 1; end
                if (!fin) pc = nxt;
            end
        end
        m_end = t;
    endtask

    int obs_busy, obs_valid, obs_xfers, obs_first_valid, obs_done_k, obs_err_k;
    int obs_fetch[$];

    task automatic run(input string tag, input int ready_from, input int mid_start,
                       input bit start_at_end);
        model(ready_from);
        obs_busy = 0; obs_valid = 0; obs_xfers = 0;
        obs_first_valid = -1; obs_done_k = -1; obs_err_k = -1;
        obs_fetch.delete();
        for (int k = 0; k <= m_end + 2; k++) begin
            @(negedge clk_i);
            start_i     = (k == 0) || (k == mid_start) || (start_at_end && k == m_end);
            bus_ready_i = (k >= ready_from);
            chk($sformatf("%s busy@%0d", tag, k),  int'(busy_o),      e_busy[k]);
            chk($sformatf("%s done@%0d", tag, k),  int'(done_o),      e_done[k]);
            chk($sformatf("%s err@%0d", tag, k),   int'(err_o),       e_err[k]);
            chk($sformatf("%s valid@%0d", tag, k), int'(bus_valid_o), e_valid[k]);
            chk($sformatf("%s rden@%0d", tag, k),  int'(rom_rden_o),  e_rden[k]);
            if (e_rden[k] != 0)
                chk($sformatf("%s rom_addr@%0d", tag, k), int'(rom_addr_o), e_raddr[k]);
            if (e_valid[k] != 0) begin
                chk($sformatf("%s bus_addr@%0d", tag, k), int'(bus_addr_o), e_baddr[k]);
                chk($sformatf("%s bus_data@%0d", tag, k), int'(bus_data_o), e_bdata[k]);
            end
            if (busy_o) obs_busy++;
            if (bus_valid_o) begin
                obs_valid++;
                if (obs_first_valid < 0) obs_first_valid = k;
                if (bus_ready_i) obs_xfers++;
            end
            if (rom_rden_o) obs_fetch.push_back(int'(rom_addr_o));
            if (done_o && obs_done_k < 0) obs_done_k = k;
            if (err_o && obs_err_k < 0) obs_err_k = k;
        end
        start_i = 1'b0;
        chk($sformatf("%s idle rom_addr", tag), int'(rom_addr_o), m_last_pc);
        $display("%s: end=%0d busy=%0d valid=%0d xfers=%0d done@%0d err@%0d",
                 tag, m_end, obs_busy, obs_valid, obs_xfers, obs_done_k, obs_err_k);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; bus_ready_i = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk_i);
        chk("reset busy",  int'(busy_o), 0);
        chk("reset done",  int'(done_o), 0);
        chk("reset err",   int'(err_o), 0);
        chk("reset rden",  int'(rom_rden_o), 0);
        chk("reset valid", int'(bus_valid_o), 0);
        chk("reset rom_addr", int'(rom_addr_o), 0);
        chk("reset bus_addr", int'(bus_addr_o), 0);
        chk("reset bus_data", int'(bus_data_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // WR a=2 d=A5; END with ready tied high; start during FINISH ignored.
        clear_rom(); rom[0] = wr(2, 8'hA5); rom[1] = mk(7, 0);
        run("t1", 0, -1, 1);
        chk("t1 model end", m_end, 8);
        chk("t1 done cycle", obs_done_k, 8);
        chk("t1 busy cycles", obs_busy, 7);
        chk("t1 xfers", obs_xfers, 1);

        // Same program, ready low for the first 5 valid cycles.
        run("t2", 9, -1, 0);
        chk("t2 valid cycles", obs_valid, 6);
        chk("t2 xfers", obs_xfers, 1);
        chk("t2 done cycle", obs_done_k, 13);

        // DLY 4; WR a=1 d=3C; END, with a stray start while busy.
        clear_rom(); rom[0] = mk(2, 4); rom[1] = wr(1, 8'h3C); rom[2] = mk(7, 0);
        run("t3", 0, 5, 0);
        chk("t3 first valid", obs_first_valid, 11);
        chk("t3 done cycle", obs_done_k, 15);

        // JMP 3 over a WR.
        clear_rom(); rom[0] = mk(3, 3); rom[1] = wr(0, 8'hFF); rom[2] = mk(0, 0);
        rom[3] = mk(7, 0);
        run("t4", 0, -1, 0);
        chk("t4 xfers", obs_xfers, 0);
        chk("t4 fetch count", obs_fetch.size(), 2);
        if (obs_fetch.size() == 2) begin
            chk("t4 fetch0", obs_fetch[0], 0);
            chk("t4 fetch1", obs_fetch[1], 3);
        end
        chk("t4 done seen", int'(obs_done_k >= 0), 1);

        // Illegal opcode 5.
        clear_rom(); rom[0] = mk(5, 0);
        run("t5", 0, -1, 0);
        chk("t5 err cycle", obs_err_k, 4);
        chk("t5 no done", obs_done_k, -1);
        chk("t5 no valid", obs_valid, 0);

        // JMP 20 out of range.
        clear_rom(); rom[0] = mk(3, 20);
        run("t6", 0, -1, 0);
        chk("t6 err cycle", obs_err_k, 4);

        // DLY 0 behaves as NOP.
        clear_rom(); rom[0] = mk(2, 0); rom[1] = mk(0, 0); rom[2] = mk(7, 0);
        run("t7", 0, -1, 0);
        chk("t7 done cycle", obs_done_k, 10);

        // PC increment past the last ROM word.
        clear_rom(); rom[0] = mk(3, 15); rom[15] = mk(0, 0);
        run("t8", 0, -1, 0);
        chk("t8 err cycle", obs_err_k, 7);
        chk("t8 last pc", int'(rom_addr_o), 15);

        // Reset while waiting in the bus handshake.
        clear_rom(); rom[0] = wr(3, 8'h11); rom[1] = mk(7, 0);
        @(negedge clk_i); start_i = 1'b1; bus_ready_i = 1'b0;
        @(negedge clk_i); start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("rst pre valid", int'(bus_valid_o), 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst valid drop", int'(bus_valid_o), 0);
        chk("rst busy drop", int'(busy_o), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("rst no done", int'(done_o), 0);
            chk("rst no err", int'(err_o), 0);
        end
        rst_i = 1'b0;
        $display("rst: reset applied during bus wait");

        // Restart fetches from address 0 again.
        clear_rom(); rom[0] = wr(2, 8'hA5); rom[1] = mk(7, 0);
        run("t9", 0, -1, 0);
        chk("t9 first fetch", (obs_fetch.size() > 0) ? obs_fetch[0] : -1, 0);
        chk("t9 done cycle", obs_done_k, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
